wb_cmd_master: RTL and testbench

Wishbone initiator that drives the FPGA-side Wishbone bus (address, cycle, strobe, write/read enables, byte strobes, write data) into the FPGA register/FIFO slave fabric. Fabric logic submits single- or multi-beat commands through a valid/ready command port and streams write data in and read data out. Targets include the FIFO access registers, which use a fixed address, and incrementing register blocks. A programmable ACK timeout aborts accesses to non-responding slaves.

---
 rtl/wb_cmd_master.sv | 170 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone initiator driving the register/FIFO slave fabric.
// Commands of 1..2**LEN_WIDTH beats arrive on a valid/ready port; write data
// streams in and read data streams out. Every beat is a separate, unpipelined
// CYC/STB window. An ACK timeout aborts the rest of the command.
module wb_cmd_master #(
   parameter int unsigned         ADRWIDTH  = 17,
   parameter int unsigned         DATAWIDTH = 32,
   parameter int unsigned         LEN_WIDTH = 4,
   parameter int unsigned         TO_WIDTH  = 8,
   parameter logic [TO_WIDTH-1:0] TO_CYCLES = 8'd255
) (
   input  logic                   WB_CLK,
   input  logic                   WB_RST,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [ADRWIDTH-1:0]    cmd_adr_i,
   input  logic                   cmd_we_i,
   input  logic                   cmd_inc_i,
   input  logic [LEN_WIDTH-1:0]   cmd_len_i,
   input  logic [DATAWIDTH/8-1:0] cmd_byte_stb_i,
   input  logic                   wdat_valid_i,
   output logic                   wdat_ready_o,
   input  logic [DATAWIDTH-1:0]   wdat_i,
   output logic                   rdat_valid_o,
   input  logic                   rdat_ready_i,
   output logic [DATAWIDTH-1:0]   rdat_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [ADRWIDTH-1:0]    WBs_ADR,
   output logic                   WBs_CYC,
   output logic                   WBs_STB,
   output logic                   WBs_WE,
   output logic                   WBs_RD,
   output logic [DATAWIDTH/8-1:0] WBs_BYTE_STB,
   output logic [DATAWIDTH-1:0]   WBs_WR_DAT,
   input  logic [DATAWIDTH-1:0]   WBs_RD_DAT,
   input  logic                   WBs_ACK
);

   localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_CYCLES - TO_WIDTH'(1);
   localparam logic [ADRWIDTH-1:0] ADR_MASK = ~ADRWIDTH'(3);
   localparam logic [ADRWIDTH-1:0] ADR_STEP = ADRWIDTH'(4);

   typedef enum logic [2:0] {IDLE, FETCH, BUS, HOLD, NEXT, DONE} state_t;

   state_t                 state, state_nxt;
   logic [LEN_WIDTH-1:0]   beat_cnt, beat_cnt_nxt;
   logic                   we_q, we_nxt;
   logic                   inc_q, inc_nxt;
   logic [TO_WIDTH-1:0]    to_cnt, to_cnt_nxt;
   logic                   err_q, err_nxt;
   logic [ADRWIDTH-1:0]    adr_nxt;
   logic [DATAWIDTH/8-1:0] stb_nxt;
   logic [DATAWIDTH-1:0]   wr_dat_nxt;
   logic [DATAWIDTH-1:0]   rdat_nxt;

   // Next-state and datapath updates; handshake outputs are decoded from the
   // next state so that every port comes straight from a flop.
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      we_nxt       = we_q;
      inc_nxt      = inc_q;
      to_cnt_nxt   = to_cnt;
      err_nxt      = err_q;
      adr_nxt      = WBs_ADR;
      stb_nxt      = WBs_BYTE_STB;
      wr_dat_nxt   = WBs_WR_DAT;
      rdat_nxt     = rdat_o;
      case (state)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               adr_nxt      = cmd_adr_i & ADR_MASK;
               we_nxt       = cmd_we_i;
               inc_nxt      = cmd_inc_i;
               stb_nxt      = cmd_byte_stb_i;
               beat_cnt_nxt = cmd_len_i;
               to_cnt_nxt   = '0;
               state_nxt    = cmd_we_i ? FETCH : BUS;
            end
         end
         FETCH: begin
            if (wdat_valid_i && wdat_ready_o) begin
               wr_dat_nxt = wdat_i;
               to_cnt_nxt = '0;
               state_nxt  = BUS;
            end
         end
         BUS: begin
            if (WBs_ACK) begin
               if (!we_q) begin
                  rdat_nxt  = WBs_RD_DAT;
                  state_nxt = HOLD;
               end else begin
                  state_nxt = NEXT;
               end
            end else if (to_cnt == TO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               to_cnt_nxt = to_cnt + TO_WIDTH'(1);
            end
         end
         HOLD: begin
            if (rdat_ready_i) state_nxt = NEXT;
         end
         NEXT: begin
            if (beat_cnt == '0) begin
               state_nxt = DONE;
            end else begin
               beat_cnt_nxt = beat_cnt - LEN_WIDTH'(1);
               if (inc_q) adr_nxt = WBs_ADR + ADR_STEP;
               to_cnt_nxt = '0;
               state_nxt  = we_q ? FETCH : BUS;
            end
         end
         DONE: begin
            err_nxt   = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         we_q         <= 1'b0;
         inc_q        <= 1'b0;
         to_cnt       <= '0;
         err_q        <= 1'b0;
         cmd_ready_o  <= 1'b1;
         wdat_ready_o <= 1'b0;
         rdat_valid_o <= 1'b0;
         rdat_o       <= '0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         WBs_ADR      <= '0;
         WBs_CYC      <= 1'b0;
         WBs_STB      <= 1'b0;
         WBs_WE       <= 1'b0;
         WBs_RD       <= 1'b0;
         WBs_BYTE_STB <= '0;
         WBs_WR_DAT   <= '0;
      end else begin
         state        <= state_nxt;
         beat_cnt     <= beat_cnt_nxt;
         we_q         <= we_nxt;
         inc_q        <= inc_nxt;
         to_cnt       <= to_cnt_nxt;
         err_q        <= err_nxt;
         cmd_ready_o  <= (state_nxt == IDLE);
         wdat_ready_o <= (state_nxt == FETCH);
         rdat_valid_o <= (state_nxt == HOLD);
         rdat_o       <= rdat_nxt;
         done_o       <= (state_nxt == DONE);
         err_o        <= (state_nxt == DONE) && err_nxt;
         WBs_ADR      <= adr_nxt;
         WBs_CYC      <= (state_nxt == BUS);
         WBs_STB      <= (state_nxt == BUS);
         WBs_WE       <= (state_nxt == BUS) && we_nxt;
         WBs_RD       <= (state_nxt == BUS) && !we_nxt;
         WBs_BYTE_STB <= stb_nxt;
         WBs_WR_DAT   <= wr_dat_nxt;
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: table-driven and randomized checks of wb_cmd_master
// against a slave model, bus window monitor and per-command expected beats.
module tb_wb_cmd_master;

   localparam logic [7:0] TOC = 8'd8;

   logic        WB_CLK, WB_RST;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_inc_i;
   logic [16:0] cmd_adr_i;
   logic [3:0]  cmd_len_i, cmd_byte_stb_i;
   logic        wdat_valid_i, wdat_ready_o;
   logic [31:0] wdat_i;
   logic        rdat_valid_o, rdat_ready_i;
   logic [31:0] rdat_o;
   logic        done_o, err_o;
   logic [16:0] WBs_ADR;
   logic        WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ACK;
   logic [3:0]  WBs_BYTE_STB;
   logic [31:0] WBs_WR_DAT, WBs_RD_DAT;

   wb_cmd_master #(.TO_CYCLES(TOC)) dut (
      .WB_CLK(WB_CLK), .WB_RST(WB_RST),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
      .cmd_we_i(cmd_we_i), .cmd_inc_i(cmd_inc_i), .cmd_len_i(cmd_len_i),
      .cmd_byte_stb_i(cmd_byte_stb_i),
      .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
      .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_o(rdat_o),
      .done_o(done_o), .err_o(err_o),
      .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE),
      .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT),
      .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK)
   );

   initial begin
      WB_CLK = 1'b0;
      forever #5 WB_CLK = ~WB_CLK;
   end

   int edge_no = 0;
   always @(posedge WB_CLK) edge_no <= edge_no + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Slave memory contents seen by reads.
   function automatic logic [31:0] rd_data(input logic [16:0] a);
      return (a == 17'h0) ? 32'h12345678 : (32'hC0DE0000 | {15'd0, a});
   endfunction

   // Slave: ACK on the ack_after-th cycle of each CYC window (0 = never);
   // optionally asserts a stray ACK whenever CYC is low.
   int ack_after = 1;
   bit stray_en  = 1'b0;
   int bus_cnt   = 0;
   int ack_edge  = 0;
   initial begin
      WBs_ACK = 1'b0;
      WBs_RD_DAT = '0;
      forever begin
         @(negedge WB_CLK);
         if (WB_RST || !WBs_CYC) begin
            bus_cnt = 0;
            WBs_ACK = stray_en && !WB_RST;
         end else begin
            bus_cnt++;
            WBs_ACK = (ack_after != 0) && (bus_cnt == ack_after);
            if (WBs_ACK) begin
               WBs_RD_DAT = rd_data(WBs_ADR);
               ack_edge = edge_no + 1;
            end
         end
      end
   end

   // Monitor: records CYC windows and output events, with the edge at which
   // each value is sampled by the DUT/slave.
   typedef struct {
      logic [16:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  stb;
      int          len;
   } win_t;
   win_t        wins[$];
   win_t        cur;
   bit          in_win = 1'b0;
   int          stab_err = 0, done_cnt = 0;
   logic        last_err = 1'b0;
   logic [31:0] rd_q[$];
   int          done_edge = -1, hs_edge = -1, acc_edge = -1, first_cyc_edge = -1;
   int          ready_rise_edge = -1, rv_rise_edge = -1;
   logic        prev_rdy = 1'b0, prev_rv = 1'b0;
   initial begin
      forever begin
         @(negedge WB_CLK);
         if (WBs_CYC) begin
            if (!in_win) begin
               in_win  = 1'b1;
               cur.adr = WBs_ADR;
               cur.we  = WBs_WE;
               cur.dat = WBs_WR_DAT;
               cur.stb = WBs_BYTE_STB;
               cur.len = 0;
               if (first_cyc_edge < 0) first_cyc_edge = edge_no + 1;
            end
            cur.len++;
            if (WBs_ADR !== cur.adr || WBs_WE !== cur.we || WBs_WR_DAT !== cur.dat ||
                WBs_BYTE_STB !== cur.stb || WBs_STB !== 1'b1 || WBs_RD !== !WBs_WE)
               stab_err++;
         end else begin
            if (in_win) begin
               wins.push_back(cur);
               in_win = 1'b0;
            end
            if (WBs_STB || WBs_WE || WBs_RD) stab_err++;
         end
         if (done_o) begin
            done_cnt++;
            last_err  = err_o;
            done_edge = edge_no + 1;
         end
         if (rdat_valid_o && rdat_ready_i) begin
            rd_q.push_back(rdat_o);
            hs_edge = edge_no + 1;
         end
         if (cmd_valid_i && cmd_ready_o) acc_edge = edge_no + 1;
         if (cmd_ready_o && !prev_rdy) ready_rise_edge = edge_no + 1;
         if (rdat_valid_o && !prev_rv) rv_rise_edge = edge_no + 1;
         prev_rdy = cmd_ready_o;
         prev_rv  = rdat_valid_o;
      end
   end

   // Write-data producer: presents queued words, optionally with gaps.
   logic [31:0] wq[$];
   int          gap_pct = 0;
   initial begin
      bit hs;
      wdat_valid_i = 1'b0;
      wdat_i = '0;
      forever begin
         @(negedge WB_CLK);
         hs = wdat_valid_i && wdat_ready_o && !WB_RST;
         @(posedge WB_CLK);
         #1;
         if (hs && wq.size() > 0) void'(wq.pop_front());
         if (wq.size() > 0 && $urandom_range(99) >= 32'(gap_pct)) begin
            wdat_valid_i = 1'b1;
            wdat_i = wq[0];
         end else begin
            wdat_valid_i = 1'b0;
         end
      end
   end

   // Read-data consumer: 0 = always ready, 1 = random, 2 = never ready.
   int rmode = 0;
   initial begin
      rdat_ready_i = 1'b1;
      forever begin
         @(posedge WB_CLK);
         #1;
         case (rmode)
            0:       rdat_ready_i = 1'b1;
            1:       rdat_ready_i = 1'($urandom_range(1));
            default: rdat_ready_i = 1'b0;
         endcase
      end
   end

   task automatic clear_sb();
      wins.delete();
      rd_q.delete();
      done_cnt = 0;
      stab_err = 0;
      first_cyc_edge = -1;
      done_edge = -1;
      ready_rise_edge = -1;
      rv_rise_edge = -1;
   endtask

   task automatic send_cmd(input logic we, input logic inc, input logic [16:0] adr,
                           input logic [3:0] len, input logic [3:0] stb);
      bit ok = 1'b0;
      @(posedge WB_CLK);
      #1;
      cmd_valid_i = 1'b1;
      cmd_we_i = we;
      cmd_inc_i = inc;
      cmd_adr_i = adr;
      cmd_len_i = len;
      cmd_byte_stb_i = stb;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge WB_CLK);
         ok = cmd_ready_o;
         @(posedge WB_CLK);
         #1;
      end
      cmd_valid_i = 1'b0;
      chk("cmd_accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input int budget);
      for (int t = 0; t < budget && done_cnt == 0; t++) @(negedge WB_CLK);
      repeat (2) @(negedge WB_CLK);
   endtask

   // Run one command and compare against the expected beat list.
   task automatic run_cmd(input string tag, input logic we, input logic inc,
                          input logic [16:0] adr, input logic [3:0] len,
                          input logic [3:0] stb, input int ack,
                          input logic [31:0] dbase, input bit drand,
                          input logic exp_err, input bit lat);
      logic [31:0] wd[$];
      logic [16:0] a;
      logic [63:0] act, exp;
      int          nb, wlen;
      clear_sb();
      ack_after = ack;
      nb   = exp_err ? 1 : int'(len) + 1;
      wlen = exp_err ? int'(TOC) : ack;
      if (we) begin
         for (int i = 0; i <= int'(len); i++) begin
            wd.push_back(drand ? $urandom : dbase + 32'(i));
            wq.push_back(wd[i]);
         end
      end
      send_cmd(we, inc, adr, len, stb);
      wait_done((int'(len) + 1) * (int'(TOC) + 40) + 40);
      chk({tag, "_done"}, 64'(done_cnt), 64'd1);
      chk({tag, "_err"}, 64'(last_err), 64'(exp_err));
      chk({tag, "_nwin"}, 64'(wins.size()), 64'(nb));
      for (int i = 0; i < wins.size() && i < nb; i++) begin
         a   = (adr & 17'h1FFFC) + (inc ? 17'(4 * i) : 17'd0);
         exp = {2'b0, a, we, stb, (we ? wd[i] : 32'h0), 8'(wlen)};
         act = {2'b0, wins[i].adr, wins[i].we, wins[i].stb,
                (wins[i].we ? wins[i].dat : 32'h0), 8'(wins[i].len)};
         chk($sformatf("%s_win%0d", tag, i), act, exp);
      end
      if (!we) begin
         chk({tag, "_nrd"}, 64'(rd_q.size()), 64'(exp_err ? 0 : nb));
         for (int i = 0; i < rd_q.size() && i < nb; i++) begin
            a = (adr & 17'h1FFFC) + (inc ? 17'(4 * i) : 17'd0);
            chk($sformatf("%s_rd%0d", tag, i), 64'(rd_q[i]), 64'(rd_data(a)));
         end
      end
      chk({tag, "_stable"}, 64'(stab_err), 64'd0);
      chk({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
      if (lat) begin
         chk({tag, "_lat_cyc"}, 64'(first_cyc_edge - acc_edge), 64'(we ? 2 : 1));
         if (!exp_err)
            chk({tag, "_lat_done"}, 64'(done_edge - (we ? ack_edge : hs_edge)), 64'd2);
         chk({tag, "_lat_rdy"}, 64'(ready_rise_edge - done_edge), 64'd1);
      end
      stray_en = 1'b0;
      wq.delete();
   endtask

   typedef struct {
      logic        we, inc;
      logic [16:0] adr;
      logic [3:0]  len, stb;
      int          ack;
      int          rm;
      bit          stray;
      logic [31:0] dbase;
      logic        exp_err;
   } vec_t;

   vec_t tbl[10];

   initial begin
      bit ok;
      int bad;
      bit      r_we, r_inc, r_err;
      int      r_ack, sel;
      logic [3:0] r_len;

      WB_RST = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_we_i = 1'b0;
      cmd_inc_i = 1'b0;
      cmd_adr_i = '0;
      cmd_len_i = '0;
      cmd_byte_stb_i = '0;

      //         we    inc   adr       len   stb   ack rm stray dbase     err
      tbl[0] = '{1'b1, 1'b0, 17'h0000C, 4'd0, 4'hF, 2, 0, 1'b0, 32'hA5, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 17'h00000, 4'd0, 4'hF, 1, 0, 1'b0, 32'h0,  1'b0};
      tbl[2] = '{1'b1, 1'b0, 17'h00100, 4'd3, 4'hF, 1, 0, 1'b0, 32'h1,  1'b0};
      tbl[3] = '{1'b0, 1'b1, 17'h1FFF8, 4'd2, 4'hF, 1, 1, 1'b0, 32'h0,  1'b0};
      tbl[4] = '{1'b0, 1'b0, 17'h00040, 4'd0, 4'hF, 0, 0, 1'b0, 32'h0,  1'b1};
      tbl[5] = '{1'b0, 1'b0, 17'h00044, 4'd1, 4'h5, 3, 0, 1'b1, 32'h0,  1'b0};
      tbl[6] = '{1'b0, 1'b1, 17'h00080, 4'd0, 4'hF, 8, 0, 1'b0, 32'h0,  1'b0};
      tbl[7] = '{1'b1, 1'b1, 17'h00040, 4'd2, 4'hF, 9, 0, 1'b0, 32'h77, 1'b1};
      tbl[8] = '{1'b1, 1'b1, 17'h1FFFF, 4'd1, 4'h3, 1, 0, 1'b1, 32'h900, 1'b0};
      tbl[9] = '{1'b0, 1'b1, 17'h00200, 4'd15, 4'hC, 1, 1, 1'b0, 32'h0, 1'b0};

      repeat (3) @(posedge WB_CLK);
      @(negedge WB_CLK);
      chk("reset_ctrl", 64'({cmd_ready_o, wdat_ready_o, rdat_valid_o, done_o, err_o,
                             WBs_CYC, WBs_STB, WBs_WE, WBs_RD}), 64'h100);
      chk("reset_data", 64'({WBs_ADR, WBs_BYTE_STB}) | 64'(WBs_WR_DAT) | 64'(rdat_o), 64'd0);
      @(posedge WB_CLK);
      #1;
      WB_RST = 1'b0;
      repeat (2) @(negedge WB_CLK);

      // Table of directed commands.
      gap_pct = 0;
      for (int i = 0; i < 10; i++) begin
         rmode = tbl[i].rm;
         stray_en = tbl[i].stray;
         run_cmd($sformatf("tbl%0d", i), tbl[i].we, tbl[i].inc, tbl[i].adr,
                 tbl[i].len, tbl[i].stb, tbl[i].ack, tbl[i].dbase, 1'b0,
                 tbl[i].exp_err, 1'b1);
      end

      // Read data held while the consumer stalls.
      clear_sb();
      rmode = 2;
      ack_after = 1;
      send_cmd(1'b0, 1'b0, 17'h00000, 4'd0, 4'hF);
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge WB_CLK);
         ok = rdat_valid_o;
      end
      chk("hold_valid", 64'(ok), 64'd1);
      chk("hold_data", 64'(rdat_o), 64'h12345678);
      bad = 0;
      repeat (5) begin
         @(negedge WB_CLK);
         if (!rdat_valid_o || rdat_o !== 32'h12345678 || done_o) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      chk("hold_rv_lat", 64'(rv_rise_edge - ack_edge), 64'd1);
      rmode = 0;
      wait_done(40);
      chk("hold_done", 64'(done_cnt), 64'd1);
      chk("hold_err", 64'(last_err), 64'd0);
      chk("hold_nrd", 64'(rd_q.size()), 64'd1);
      if (rd_q.size() > 0) chk("hold_rd", 64'(rd_q[0]), 64'h12345678);
      chk("hold_lat_done", 64'(done_edge - hs_edge), 64'd2);
      chk("hold_win", 64'({wins.size() == 1, (wins.size() > 0) ? wins[0].we : 1'b1}), 64'b10);

      // Reset during the second beat of a FIFO burst.
      clear_sb();
      ack_after = 3;
      for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
      send_cmd(1'b1, 1'b0, 17'h00100, 4'd3, 4'hF);
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge WB_CLK);
         ok = in_win && (wins.size() == 1);
      end
      chk("rst_beat2_seen", 64'(ok), 64'd1);
      @(posedge WB_CLK);
      #1;
      WB_RST = 1'b1;
      @(posedge WB_CLK);
      @(negedge WB_CLK);
      chk("rst_cyc_low", 64'({WBs_CYC, WBs_STB, done_o, cmd_ready_o}), 64'b0001);
      @(posedge WB_CLK);
      #1;
      WB_RST = 1'b0;
      wq.delete();
      repeat (5) @(negedge WB_CLK);
      chk("rst_no_done", 64'(done_cnt), 64'd0);
      chk("rst_ready", 64'(cmd_ready_o), 64'd1);

      // Randomized commands against the expected beat model.
      for (int n = 0; n < 40; n++) begin
         r_we  = 1'($urandom_range(1));
         r_inc = 1'($urandom_range(1));
         r_len = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
         sel   = int'($urandom_range(9));
         r_ack = (sel == 0) ? 0 : (sel == 1) ? 8 : (sel == 2) ? 9 : int'($urandom_range(4, 1));
         r_err = (r_ack == 0) || (r_ack > int'(TOC));
         rmode = int'($urandom_range(1));
         gap_pct = ($urandom_range(1) == 0) ? 0 : 40;
         stray_en = 1'($urandom_range(1));
         run_cmd($sformatf("rnd%0d", n), r_we, r_inc, 17'($urandom), r_len,
                 4'($urandom), r_ack, 32'h0, 1'b1, r_err, gap_pct == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
